expression_pipe_lanes: RTL and testbench

//   Parametrised, pipelined successor to the flat combinational expression blocks.

---
 rtl/expression_pipe_lanes_if.sv | 28 ++
 rtl/expression_pipe_lanes.sv | 166 ++++++++++++++++
 tb/tb_expression_pipe_lanes.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/expression_pipe_lanes_if.sv
// Operand/result handshake bundle for expression_pipe_lanes.
// master = stimulus source + result consumer, slave = the pipeline.
interface expression_pipe_lanes_if #(
    parameter int W     = 8,
    parameter int LANES = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [LANES*W-1:0] in_a;
    logic [LANES*W-1:0] in_b;
    logic [LANES*3-1:0] in_op;
    logic [LANES-1:0]   in_signed;
    logic               out_valid;
    logic               out_ready;
    logic [LANES*W-1:0] out_y;
    logic [LANES-1:0]   ovf;
    logic               ovf_clr;

    modport master (
        output in_valid, in_a, in_b, in_op, in_signed, out_ready, ovf_clr,
        input  in_ready, out_valid, out_y, ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_signed, out_ready, ovf_clr,
        output in_ready, out_valid, out_y, ovf
    );
endinterface

// File: rtl/expression_pipe_lanes.sv
// Two-stage valid/ready pipeline of LANES independent opcode-selected W-bit ALUs.
// Optional build macro EXPR_PIPE_SAT_EN makes ADD/SUB saturate instead of wrap.
module expression_pipe_lanes #(
    parameter int W     = 8,
    parameter int LANES = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    expression_pipe_lanes_if.slave bus
);

    localparam logic [W-1:0] W_LIM = W[W-1:0];

`ifdef EXPR_PIPE_SAT_EN
    function automatic logic [W-1:0] clamp(input logic sgn, input logic neg, input logic is_sub);
        logic [W-1:0] v;
        if (sgn) begin
            v = neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            v = is_sub ? {W{1'b0}} : {W{1'b1}};
        end
        return v;
    endfunction
`endif

    // Returns {overflow, result}; operands are widened by one bit so ext[W] is the true sign/carry.
    function automatic logic [W:0] eval_lane(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] op, input logic sgn);
        logic [W:0]          ea;
        logic [W:0]          eb;
        logic [W:0]          ext;
        logic [W-1:0]        y;
        logic                ov;
        logic                lt;
        logic signed [W-1:0] sa;
        ea  = sgn ? {a[W-1], a} : {1'b0, a};
        eb  = sgn ? {b[W-1], b} : {1'b0, b};
        ext = {(W+1){1'b0}};
        y   = {W{1'b0}};
        ov  = 1'b0;
        lt  = 1'b0;
        sa  = a;
        case (op)
            3'd0: begin
                ext = ea + eb;
                y   = ext[W-1:0];
                ov  = sgn ? (ext[W] ^ ext[W-1]) : ext[W];
`ifdef EXPR_PIPE_SAT_EN
                if (ov) y = clamp(sgn, ext[W], 1'b0);
                else    y = ext[W-1:0];
`endif
            end
            3'd1: begin
                ext = ea - eb;
                y   = ext[W-1:0];
                ov  = sgn ? (ext[W] ^ ext[W-1]) : ext[W];
`ifdef EXPR_PIPE_SAT_EN
                if (ov) y = clamp(sgn, ext[W], 1'b1);
                else    y = ext[W-1:0];
`endif
            end
            3'd2: y = a * b;
            3'd3: y = a ~^ b;
            3'd4: begin
                if (b >= W_LIM) y = {W{1'b0}};
                else            y = a << b;
            end
            3'd5: begin
                // kept as separate branches so >>> stays arithmetic on the signed temp
                if (b >= W_LIM) y = sgn ? {W{a[W-1]}} : {W{1'b0}};
                else if (sgn)   y = sa >>> b;
                else            y = a >> b;
            end
            3'd6: begin
                lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
                y  = {{(W-1){1'b0}}, lt};
            end
            3'd7: y = {{(W-1){1'b0}}, ^(a & b)};
            default: y = {W{1'b0}};
        endcase
        return {ov, y};
    endfunction

    logic               s1_valid_r;
    logic [LANES*W-1:0] s1_a_r;
    logic [LANES*W-1:0] s1_b_r;
    logic [LANES*3-1:0] s1_op_r;
    logic [LANES-1:0]   s1_signed_r;
    logic               s2_valid_r;
    logic [LANES*W-1:0] s2_y_r;
    logic [LANES-1:0]   ovf_r;

    logic               s2_adv_s;
    logic               s1_adv_s;
    logic               in_ready_s;
    logic               accept_s;
    logic [LANES*W-1:0] calc_y_s;
    logic [LANES-1:0]   calc_ovf_s;
    logic [LANES-1:0]   ovf_set_s;

    assign s2_adv_s   = !s2_valid_r || bus.out_ready;
    assign s1_adv_s   = s1_valid_r && s2_adv_s;
    assign in_ready_s = !s1_valid_r || s2_adv_s;
    assign accept_s   = bus.in_valid && in_ready_s;
    assign ovf_set_s  = s1_adv_s ? calc_ovf_s : {LANES{1'b0}};

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = s2_valid_r;
    assign bus.out_y     = s2_y_r;
    assign bus.ovf       = ovf_r;

    // Per-lane expression evaluation on the S1 operands.
    always_comb begin
        calc_y_s   = {(LANES*W){1'b0}};
        calc_ovf_s = {LANES{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            {calc_ovf_s[i], calc_y_s[i*W +: W]} =
                eval_lane(s1_a_r[i*W +: W], s1_b_r[i*W +: W], s1_op_r[i*3 +: 3], s1_signed_r[i]);
        end
    end

    // Stage 1: operand capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r  <= 1'b0;
            s1_a_r      <= {(LANES*W){1'b0}};
            s1_b_r      <= {(LANES*W){1'b0}};
            s1_op_r     <= {(LANES*3){1'b0}};
            s1_signed_r <= {LANES{1'b0}};
        end else if (accept_s) begin
            s1_valid_r  <= 1'b1;
            s1_a_r      <= bus.in_a;
            s1_b_r      <= bus.in_b;
            s1_op_r     <= bus.in_op;
            s1_signed_r <= bus.in_signed;
        end else if (s1_adv_s) begin
            s1_valid_r  <= 1'b0;
        end else begin
            s1_valid_r  <= s1_valid_r;
        end
    end

    // Stage 2: result capture, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_y_r     <= {(LANES*W){1'b0}};
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) s2_y_r <= calc_y_s;
            else            s2_y_r <= s2_y_r;
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    // Sticky overflow flags; a same-cycle set overrides the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_r <= {LANES{1'b0}};
        end else begin
            ovf_r <= (bus.ovf_clr ? {LANES{1'b0}} : ovf_r) | ovf_set_s;
        end
    end

endmodule

// File: tb/tb_expression_pipe_lanes.sv
// Directed self-checking bench for expression_pipe_lanes (W=8, LANES=4).
module tb_expression_pipe_lanes;
    localparam int W     = 8;
    localparam int LANES = 4;
`ifdef EXPR_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    expression_pipe_lanes_if #(.W(W), .LANES(LANES)) bus ();
    expression_pipe_lanes #(.W(W), .LANES(LANES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Integer-arithmetic reference for one lane.
    function automatic logic [7:0] ref_lane(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op, input logic sgn);
        int ia, ib, r, lo, hi;
        ia = sgn ? int'($signed(a)) : int'(a);
        ib = sgn ? int'($signed(b)) : int'(b);
        lo = sgn ? -128 : 0;
        hi = sgn ? 127 : 255;
        r  = 0;
        case (op)
            3'd0, 3'd1: begin
                r = (op == 3'd0) ? ia + ib : ia - ib;
                if (SAT && r > hi) r = hi;
                if (SAT && r < lo) r = lo;
            end
            3'd2: r = ia * ib;
            3'd3: r = {24'd0, ~(a ^ b)};
            3'd4: r = (b >= 8'd8) ? 0 : int'(a) * (1 << b);
            3'd5: begin
                if (sgn) r = (b >= 8'd8) ? ((ia < 0) ? -1 : 0) : (ia >>> b);
                else     r = (b >= 8'd8) ? 0 : (int'(a) >> b);
            end
            3'd6: r = (ia < ib) ? 1 : 0;
            default: r = (^(a & b)) ? 1 : 0;
        endcase
        return r[7:0];
    endfunction

    function automatic logic [31:0] ref_bundle(input logic [31:0] a, input logic [31:0] b,
                                               input logic [11:0] op, input logic [3:0] sg);
        logic [31:0] y;
        for (int i = 0; i < LANES; i++) y[i*8 +: 8] = ref_lane(a[i*8 +: 8], b[i*8 +: 8], op[i*3 +: 3], sg[i]);
        return y;
    endfunction

    // Presents one bundle, checks exact two-cycle latency; returns at the negedge result is visible.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [11:0] op,
                         input logic [3:0] sg, input logic clr_mid);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_op = op; bus.in_signed = sg;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_val("latency_early_valid", bus.out_valid, 1'b0);
        bus.ovf_clr = clr_mid;
        @(posedge clk);
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        check_val("latency_out_valid", bus.out_valid, 1'b1);
    endtask

    task automatic clear_ovf();
        @(negedge clk);
        bus.ovf_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        check_val("ovf_after_clr", bus.ovf, 4'b0000);
    endtask

    logic [31:0] st_a [16];
    logic [31:0] st_b [16];
    logic [11:0] st_op[16];
    logic [3:0]  st_sg[16];
    logic [31:0] exp_q[$];
    int sent, rcvd;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = 32'd0; bus.in_b = 32'd0; bus.in_op = 12'd0;
        bus.in_signed = 4'd0; bus.out_ready = 1'b1; bus.ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_val("rst_out_valid", bus.out_valid, 1'b0);
        check_val("rst_out_y", bus.out_y, 32'd0);
        check_val("rst_ovf", bus.ovf, 4'b0000);
        check_val("rst_in_ready", bus.in_ready, 1'b1);

        // 1) unsigned ADD overflow on lane 0
        issue(32'h000000C8, 32'h00000064, 12'd0, 4'b0000, 1'b0);
        check_val("add_u_y", bus.out_y, SAT ? 32'h000000FF : 32'h0000002C);
        check_val("add_u_ovf", bus.ovf, 4'b0001);
        clear_ovf();

        // 2) signed SUB overflow, then clear colliding with a new set on lane 1
        issue(32'h00000080, 32'h00000001, {3'd0, 3'd0, 3'd0, 3'd1}, 4'b0001, 1'b0);
        check_val("sub_s_y", bus.out_y, SAT ? 32'h00000080 : 32'h0000007F);
        check_val("sub_s_ovf", bus.ovf, 4'b0001);
        issue(32'h0000FF00, 32'h00000100, 12'd0, 4'b0000, 1'b1);
        check_val("set_wins_y", bus.out_y, SAT ? 32'h0000FF00 : 32'h00000000);
        check_val("set_wins_ovf", bus.ovf, 4'b0010);
        clear_ovf();

        // 3) shifts and compares
        issue(32'hFF019090, 32'h01070909, {3'd6, 3'd4, 3'd5, 3'd5}, 4'b1001, 1'b0);
        check_val("shift_a_y", bus.out_y, 32'h018000FF);
        issue(32'h908190FF, 32'h03080201, {3'd5, 3'd4, 3'd5, 3'd6}, 4'b0010, 1'b0);
        check_val("shift_b_y", bus.out_y, 32'h1200E400);
        check_val("shift_ovf", bus.ovf, 4'b0000);

        // 6) distinct op per lane, then mixed ADD/SUB overflow cases
        issue(32'h0FF00C0A, 32'h07AA0D14, {3'd7, 3'd3, 3'd2, 3'd0}, 4'b0000, 1'b0);
        check_val("lanes_y", bus.out_y, 32'h01A59C1E);
        check_val("lanes_ovf", bus.ovf, 4'b0000);
        issue(32'h059C6405, 32'h039C640A, {3'd1, 3'd0, 3'd0, 3'd1}, 4'b1110, 1'b0);
        check_val("addsub_y", bus.out_y, SAT ? 32'h02807F00 : 32'h0238C8FB);
        check_val("addsub_ovf", bus.ovf, 4'b0111);
        clear_ovf();

        // 4) streaming with toggling then stuck-low out_ready
        for (int i = 0; i < 16; i++) begin
            st_a[i]  = $urandom;
            st_b[i]  = $urandom;
            st_op[i] = 12'($urandom);
            st_sg[i] = 4'($urandom);
        end
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            bus.out_ready = (cyc < 12) ? ((cyc % 2) == 0) : (cyc >= 17);
            if (sent < 16) begin
                bus.in_valid = 1'b1; bus.in_a = st_a[sent]; bus.in_b = st_b[sent];
                bus.in_op = st_op[sent]; bus.in_signed = st_sg[sent];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (cyc == 16) begin
                check_val("stall_in_ready", bus.in_ready, 1'b0);
                check_val("stall_out_valid", bus.out_valid, 1'b1);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check_val("stream_unexpected_valid", bus.out_valid, 1'b0);
                else check_val("stream_y", bus.out_y, exp_q.pop_front());
                rcvd++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_bundle(bus.in_a, bus.in_b, bus.in_op, bus.in_signed));
                sent++;
            end
            if (sent == 16 && exp_q.size() == 0 && cyc > 17) break;
        end
        repeat (3) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            check_val("stream_no_dup", bus.out_valid, 1'b0);
        end
        check_val("stream_sent", sent, 16);
        check_val("stream_rcvd", rcvd, 16);
        clear_ovf();

        // 5) reset with two bundles in flight
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 32'h000000C8; bus.in_b = 32'h00000064;
        bus.in_op = 12'd0; bus.in_signed = 4'd0;
        @(posedge clk);
        @(negedge clk);
        bus.in_a = 32'h01010101; bus.in_b = 32'h01010101;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_val("inflight_ovf", bus.ovf, 4'b0001);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_val("midrst_out_valid", bus.out_valid, 1'b0);
        check_val("midrst_ovf", bus.ovf, 4'b0000);
        check_val("midrst_in_ready", bus.in_ready, 1'b1);
        bus.out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_val("midrst_no_stale", bus.out_valid, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
